// File: rtl/pill_led_alarm.sv
// Per-channel pill reminder: a WAIT/ALERT/MISSED/TAKEN FSM with a blinking LED
// per channel, plus a shared alarm flag and a saturating missed-dose counter.

module pill_led_alarm_ch #(
    parameter int DUR_W         = 4,
    parameter int BLINK_DIV     = 25000000,
    parameter int ALERT_TOGGLES = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DUR_W-1:0] dur,
    input  logic             ack,
    output logic             led,
    output logic             alarm_nxt,
    output logic             miss_enter
);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int TW = $clog2(ALERT_TOGGLES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [TW-1:0] TOG_LAST   = TW'(ALERT_TOGGLES - 1);

    typedef enum logic [1:0] {S_WAIT, S_ALERT, S_MISSED, S_TAKEN} state_e;

    state_e        state_q, state_d;
    logic          led_q, led_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [TW-1:0] tog_q, tog_d;
    logic          due;

    assign due = (dur == '0);

    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        blink_d    = blink_q;
        tog_d      = tog_q;
        miss_enter = 1'b0;
        case (state_q)
            S_WAIT: begin
                led_d = 1'b0;
                if (due) begin
                    state_d = S_ALERT;
                    led_d   = 1'b1;
                    blink_d = '0;
                    tog_d   = '0;
                end
            end
            S_ALERT: begin
                if (!due) begin
                    state_d = S_WAIT;
                    led_d   = 1'b0;
                end else if (ack) begin
                    state_d = S_TAKEN;
                    led_d   = 1'b0;
                end else if (blink_q == BLINK_LAST) begin
                    blink_d = '0;
                    // The final wrap ends the alert instead of toggling.
                    if (tog_q == TOG_LAST) begin
                        state_d    = S_MISSED;
                        led_d      = 1'b1;
                        miss_enter = 1'b1;
                    end else begin
                        led_d = ~led_q;
                        tog_d = tog_q + 1'b1;
                    end
                end else begin
                    blink_d = blink_q + 1'b1;
                end
            end
            S_MISSED: begin
                led_d = 1'b1;
                if (!due) begin
                    state_d = S_WAIT;
                    led_d   = 1'b0;
                end else if (ack) begin
                    state_d = S_TAKEN;
                    led_d   = 1'b0;
                end
            end
            S_TAKEN: begin
                led_d = 1'b0;
                if (!due) state_d = S_WAIT;
            end
            default: begin
                state_d = S_WAIT;
                led_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            led_q   <= 1'b0;
            blink_q <= '0;
            tog_q   <= '0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            blink_q <= blink_d;
            tog_q   <= tog_d;
        end
    end

    assign led       = led_q;
    assign alarm_nxt = (state_d == S_ALERT) || (state_d == S_MISSED);
endmodule

module pill_led_alarm #(
    parameter int NUM_PILLS     = 3,
    parameter int DUR_W         = 4,
    parameter int BLINK_DIV     = 25000000,
    parameter int ALERT_TOGGLES = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_PILLS*DUR_W-1:0] pill_durations,
    input  logic [NUM_PILLS-1:0]       ack,
    output logic [NUM_PILLS-1:0]       pill_leds,
    output logic                       alarm,
    output logic [7:0]                 missed_total
);
    logic [NUM_PILLS-1:0] alarm_nxt;
    logic [NUM_PILLS-1:0] miss_enter;
    logic                 alarm_q, alarm_d;
    logic [7:0]           missed_q, missed_d;
    logic [3:0]           miss_cnt;
    logic [8:0]           miss_sum;

    for (genvar g = 0; g < NUM_PILLS; g++) begin : g_ch
        pill_led_alarm_ch #(
            .DUR_W        (DUR_W),
            .BLINK_DIV    (BLINK_DIV),
            .ALERT_TOGGLES(ALERT_TOGGLES)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .dur       (pill_durations[g*DUR_W +: DUR_W]),
            .ack       (ack[g]),
            .led       (pill_leds[g]),
            .alarm_nxt (alarm_nxt[g]),
            .miss_enter(miss_enter[g])
        );
    end

    always_comb begin
        miss_cnt = '0;
        for (int i = 0; i < NUM_PILLS; i++) miss_cnt = miss_cnt + {3'b0, miss_enter[i]};
        miss_sum = {1'b0, missed_q} + {5'b0, miss_cnt};
        missed_d = miss_sum[8] ? 8'hFF : miss_sum[7:0];
        alarm_d  = |alarm_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alarm_q  <= 1'b0;
            missed_q <= '0;
        end else begin
            alarm_q  <= alarm_d;
            missed_q <= missed_d;
        end
    end

    assign alarm        = alarm_q;
    assign missed_total = missed_q;
endmodule

// File: tb/tb_pill_led_alarm.sv
// Directed bench for pill_led_alarm with BLINK_DIV=4, ALERT_TOGGLES=3:
// a vector table for the channel scenarios, then a loop for counter saturation.

module tb_pill_led_alarm;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] dur;
    logic [2:0]  ack;
    logic [2:0]  leds;
    logic        alarm;
    logic [7:0]  missed;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst_n;
        logic [11:0] dur;
        logic [2:0]  ack;
        logic [2:0]  leds;
        logic        alarm;
        logic [7:0]  missed;
    } vec_t;

    vec_t vecs[$];

    pill_led_alarm #(
        .NUM_PILLS    (3),
        .DUR_W        (4),
        .BLINK_DIV    (4),
        .ALERT_TOGGLES(3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pill_durations(dur),
        .ack           (ack),
        .pill_leds     (leds),
        .alarm         (alarm),
        .missed_total  (missed)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [11:0] d, input logic [2:0] a,
                       input logic [2:0] l, input logic al, input logic [7:0] m);
        vec_t v;
        v.rst_n = r; v.dur = d; v.ack = a; v.leds = l; v.alarm = al; v.missed = m;
        vecs.push_back(v);
    endtask

    // 13 edges from ALERT entry to MISSED: LED on 0..3, off 4..7, on 8..12.
    task automatic add_miss_seq(input logic [11:0] d, input logic [2:0] mask,
                                input logic [7:0] m0, input int n);
        for (int i = 0; i <= 12; i++)
            add(1'b1, d, 3'b000, (i < 4 || i >= 8) ? mask : 3'b000, 1'b1,
                (i == 12) ? m0 + 8'(n) : m0);
    endtask

    task automatic step(input logic r, input logic [11:0] d, input logic [2:0] a);
        rst_n = r; dur = d; ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input int id, input logic [2:0] el, input logic ea,
                         input logic [7:0] em);
        checks++;
        if (leds !== el || alarm !== ea || missed !== em) begin
            errors++;
            $display("FAIL vec%0d leds/alarm/missed got %b/%b/%0d want %b/%b/%0d",
                     id, leds, alarm, missed, el, ea, em);
        end
    endtask

    initial begin
        int exp_m;
        rst_n = 1'b0; dur = 12'h111; ack = 3'b000;

        // reset and idle
        add(1'b0, 12'h111, 3'b000, 3'b000, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) add(1'b1, 12'h111, 3'b000, 3'b000, 1'b0, 8'd0);
        // channel 1 times out, stays MISSED, then released
        add_miss_seq(12'h101, 3'b010, 8'd0, 1);
        add(1'b1, 12'h101, 3'b000, 3'b010, 1'b1, 8'd1);
        add(1'b1, 12'h111, 3'b000, 3'b000, 1'b0, 8'd1);
        // channel 0 acked at k+5, then released; later ack ignored
        for (int i = 0; i <= 4; i++)
            add(1'b1, 12'h110, 3'b000, (i < 4) ? 3'b001 : 3'b000, 1'b1, 8'd1);
        add(1'b1, 12'h110, 3'b001, 3'b000, 1'b0, 8'd1);
        add(1'b1, 12'h110, 3'b000, 3'b000, 1'b0, 8'd1);
        add(1'b1, 12'h113, 3'b000, 3'b000, 1'b0, 8'd1);
        add(1'b1, 12'h113, 3'b001, 3'b000, 1'b0, 8'd1);
        add(1'b1, 12'h113, 3'b000, 3'b000, 1'b0, 8'd1);
        // ack with nonzero duration in ALERT goes to WAIT, so due re-alerts
        add(1'b1, 12'h110, 3'b000, 3'b001, 1'b1, 8'd1);
        add(1'b1, 12'h111, 3'b001, 3'b000, 1'b0, 8'd1);
        add(1'b1, 12'h110, 3'b000, 3'b001, 1'b1, 8'd1);
        add(1'b1, 12'h111, 3'b000, 3'b000, 1'b0, 8'd1);
        // all three miss together, twice
        add_miss_seq(12'h000, 3'b111, 8'd1, 3);
        add(1'b1, 12'h111, 3'b000, 3'b000, 1'b0, 8'd4);
        add_miss_seq(12'h000, 3'b111, 8'd4, 3);
        // release ch0/ch1, ch2 stays MISSED; reset for one edge, re-alert
        add(1'b1, 12'h011, 3'b000, 3'b100, 1'b1, 8'd7);
        add(1'b0, 12'h011, 3'b000, 3'b000, 1'b0, 8'd0);
        add(1'b1, 12'h011, 3'b000, 3'b100, 1'b1, 8'd0);
        add(1'b0, 12'h111, 3'b000, 3'b000, 1'b0, 8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].dur, vecs[i].ack);
            check(i, vecs[i].leds, vecs[i].alarm, vecs[i].missed);
        end

        // saturation: 84 triple misses + 2 single misses reach 254
        exp_m = 0;
        step(1'b0, 12'h111, 3'b000);
        for (int r = 0; r < 86; r++) begin
            for (int i = 0; i <= 12; i++) step(1'b1, (r < 84) ? 12'h000 : 12'h101, 3'b000);
            exp_m += (r < 84) ? 3 : 1;
            step(1'b1, 12'h111, 3'b000);
        end
        check(1000, 3'b000, 1'b0, 8'(exp_m));
        for (int i = 0; i <= 12; i++) step(1'b1, 12'h000, 3'b000);
        check(1001, 3'b111, 1'b1, 8'd255);
        step(1'b1, 12'h111, 3'b000);
        for (int i = 0; i <= 12; i++) step(1'b1, 12'h000, 3'b000);
        check(1002, 3'b111, 1'b1, 8'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pill_led_alarm.md
PILL_LED_ALARM -- requirements
Module: pill_led_alarm

Interface
REQ-001 SHALL have parameter NUM_PILLS, default 3: number of pill channels, legal range 1..8.
REQ-002 SHALL have parameter DUR_W, default 4: bits per channel duration field, minimum 1.
REQ-003 SHALL have parameter BLINK_DIV, default 25000000: clock cycles per LED toggle in ALERT, minimum 2.
REQ-004 SHALL have parameter ALERT_TOGGLES, default 20: toggle periods spent in ALERT before MISSED, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port pill_durations, input, NUM_PILLS*DUR_W bits: remaining time per channel; channel i occupies bits [i*DUR_W +: DUR_W], so channel 0 is the LSB field.
REQ-008 SHALL have port ack, input, NUM_PILLS bits: per-channel "dose taken" strobe, level-sampled each cycle.
REQ-009 SHALL have port pill_leds, output, NUM_PILLS bits: per-channel LED drive, registered.
REQ-010 SHALL have port alarm, output, 1 bit: registered; high when any channel is in ALERT or MISSED.
REQ-011 SHALL have port missed_total, output, 8 bits: registered, saturating count of MISSED entries.

Function
REQ-012 SHALL implement one independent FSM per channel with states WAIT, ALERT, MISSED, TAKEN.
REQ-013 A channel is "due" when its duration field equals 0, sampled at each rising edge.
REQ-014 WAIT: on a due edge go to ALERT; otherwise stay. Ack is ignored.
REQ-015 ALERT: if not due, go to WAIT. Else if ack, go to TAKEN. Else if the ALERT_TOGGLES-th blink wrap occurs this edge, go to MISSED.
REQ-016 MISSED: if not due, go to WAIT. Else if ack, go to TAKEN. Otherwise stay.
REQ-017 TAKEN: if not due, go to WAIT; otherwise stay.
REQ-018 Priority within a channel: not-due beats ack, and ack beats the timeout.
REQ-019 Each channel SHALL have a blink counter 0..BLINK_DIV-1 and a toggle counter, both cleared on ALERT entry.
REQ-020 Blink counter increments each ALERT cycle; a wrap occurs on the edge where it would reach BLINK_DIV, and the counter returns to 0.
REQ-021 The LED register and state SHALL update on the same edge.
REQ-022 LED value per state: WAIT=0; ALERT entry=1; MISSED=1; TAKEN=0.
REQ-023 In ALERT, each wrap that does not cause MISSED toggles the LED and increments the toggle counter.
REQ-024 The wrap numbered ALERT_TOGGLES causes MISSED instead of a toggle.
REQ-025 The ALERT timeout SHALL therefore be ALERT_TOGGLES*BLINK_DIV cycles after entry.
REQ-026 alarm SHALL be registered from next-state and SHALL reflect the same edge as the states.
REQ-027 missed_total SHALL add the number of channels entering MISSED on that edge, saturating at 255.
REQ-028 Channels SHALL not interact except through alarm and missed_total.

Reset
REQ-029 On a rising edge with rst_n=0, all channels go to WAIT, and pill_leds=0, alarm=0, missed_total=0, all counters 0.
REQ-030 Reset SHALL take priority over every other condition, including mid-ALERT or MISSED.
REQ-031 The first edge with rst_n=1 SHALL evaluate inputs normally: a due channel enters ALERT on that edge.

Verification
REQ-032 Bench SHALL cover, with NUM_PILLS=3, DUR_W=4, BLINK_DIV=4, ALERT_TOGGLES=3:
- Reset, then durations 0x111 -> pill_leds=000, alarm=0, missed_total=0 indefinitely.
- Channel 1 field set to 0 before edge k -> at edge k: pill_leds[1]=1 and alarm=1. Then pill_leds[1]=0 at k+4, =1 at k+8. At k+12: MISSED, pill_leds[1]=1, missed_total=1.
- Channel 0 due at edge k, ack[0]=1 at edge k+5 -> TAKEN, pill_leds[0]=0, alarm=0. Then field set to 3 -> WAIT; a later ack[0] has no effect.
- All three due at the same edge, no ack -> all MISSED on the same edge and missed_total increases by 3. With missed_total=254 beforehand, it becomes 255.
- In ALERT, ack and a nonzero duration asserted on the same edge -> WAIT (not TAKEN), LED=0.
- rst_n=0 for one edge while channel 2 is in MISSED with missed_total=7 -> all outputs 0. If still due, ALERT is re-entered on the first edge after reset release.
